uart_rx_stream: RTL and testbench

//  Next-generation UART receive path: oversampling receiver, FIFO and registered valid/ready output stage.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_fifo_core.sv | 48 ++++
 rtl/uart_rx_stream.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx_stream.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, error-flag
// indices and the baud divisor / majority helpers used by both RX and TX.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int ERR_PARITY = 0;
  localparam int ERR_FRAME  = 1;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_divisor(input int clk_mhz, input int baud);
    longint num;
    num = longint'(clk_mhz) * 1_000_000 + longint'(baud) * 8;
    return int'(num / (longint'(baud) * 16));
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_core.sv
// Synchronous FIFO with combinational read port; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module uart_rx_fifo_core #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_stream.sv
// Oversampling UART receiver with FIFO and prefetching valid/ready output stage.
// Optional idle-timeout interrupt is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BAUDRATE     = 9600,
  parameter int CLK_FREQ_MHZ = 125,
  parameter int OVERSAMPLE   = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int WATERMARK    = 8,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          clr_overrun,
  input  logic                          ready_out,
  output logic                          valid_out,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic [1:0]                    rx_err,
  output logic [$clog2(FIFO_DEPTH)+1:0] fifo_level,
  output logic                          rx_done,
  output logic                          overrun,
  output logic                          irq_wm,
  output logic                          irq_timeout
);
  localparam int DIV    = calc_divisor(CLK_FREQ_MHZ, BAUDRATE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int MID    = OVERSAMPLE / 2;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int LVL_W  = CNT_W + 1;
  localparam int WORD_W = DATA_WIDTH + 2;

  logic rx_meta, rx_sync, rx_prev;
  logic start_edge, frame_start;
  rx_state_t state, state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic tick, sample_pt, bit_end, bit_val, frame_last;
  logic [1:0] samp;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_idx;
  logic [1:0] par_mode_q;
  logic stop2_q, par_err, frame_err, par_en, par_expect;
  logic [WORD_W-1:0] word_q, fifo_rdata;
  logic fifo_full, fifo_empty, pop, drop;
  logic [CNT_W-1:0] fifo_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge  = rx_prev & ~rx_sync;
  assign frame_start = (state == ST_IDLE) & start_edge;
  assign tick        = (div_cnt == DIV_W'(DIV - 1));
  assign sample_pt   = tick & (tick_cnt == TICK_W'(MID + 1));
  assign bit_end     = tick & (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign bit_val     = majority3(samp[1], samp[0], rx_sync);
  assign par_en      = (par_mode_q == PAR_EVEN) | (par_mode_q == PAR_ODD);
  assign par_expect  = (par_mode_q == PAR_ODD) ? ~^shreg : ^shreg;

  // Tick counters free-run while idle so the timeout can count bit-times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      samp     <= '0;
    end else begin
      if (frame_start) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        div_cnt  <= '0;
        tick_cnt <= tick_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (tick && (tick_cnt == TICK_W'(MID - 1) || tick_cnt == TICK_W'(MID)))
        samp <= {samp[0], rx_sync};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_last = 1'b0;
    case (state)
      ST_IDLE:   if (start_edge) state_next = ST_START;
      ST_START: begin
        if (sample_pt && bit_val) state_next = ST_IDLE;
        else if (bit_end)         state_next = ST_DATA;
      end
      ST_DATA:
        if (bit_end && bit_idx == BIT_W'(DATA_WIDTH))
          state_next = par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (bit_end) state_next = ST_STOP1;
      ST_STOP1: begin
        if (stop2_q) begin
          if (bit_end) state_next = ST_STOP2;
        end else if (sample_pt) begin
          state_next = ST_IDLE;
          frame_last = 1'b1;
        end
      end
      ST_STOP2: begin
        if (sample_pt) begin
          state_next = ST_IDLE;
          frame_last = 1'b1;
        end
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // The word is captured at the last stop sample and pushed the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      bit_idx    <= '0;
      par_mode_q <= PAR_NONE;
      stop2_q    <= 1'b0;
      par_err    <= 1'b0;
      frame_err  <= 1'b0;
      word_q     <= '0;
      rx_done    <= 1'b0;
    end else begin
      rx_done <= frame_last;
      if (frame_start) begin
        par_mode_q <= cfg_parity;
        stop2_q    <= cfg_stop2;
        bit_idx    <= '0;
        par_err    <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (sample_pt) begin
        case (state)
          ST_DATA: begin
            shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          ST_PARITY:          par_err <= (bit_val != par_expect);
          ST_STOP1, ST_STOP2: if (!bit_val) frame_err <= 1'b1;
          default: ;
        endcase
      end
      if (frame_last) begin
        word_q[DATA_WIDTH-1:0]         <= shreg;
        word_q[DATA_WIDTH + ERR_PARITY] <= par_err;
        word_q[DATA_WIDTH + ERR_FRAME]  <= frame_err | ~bit_val;
      end
    end
  end

  uart_rx_fifo_core #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_done),
    .pop   (pop),
    .wdata (word_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop  = ~fifo_empty & (~valid_out | ready_out);
  assign drop = rx_done & fifo_full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      rx_data   <= '0;
      rx_err    <= '0;
    end else if (pop) begin
      valid_out         <= 1'b1;
      {rx_err, rx_data} <= fifo_rdata;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  assign fifo_level = LVL_W'(fifo_count) + LVL_W'(valid_out);
  assign irq_wm     = (fifo_level >= LVL_W'(WATERMARK));

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_BITS + 1);
  logic [TO_W-1:0] idle_bits;
  logic            to_fired;

  // One pulse per idle period; any start edge or active frame re-arms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_bits   <= '0;
      to_fired    <= 1'b0;
      irq_timeout <= 1'b0;
    end else begin
      irq_timeout <= 1'b0;
      if (state != ST_IDLE || start_edge) begin
        idle_bits <= '0;
        to_fired  <= 1'b0;
      end else begin
        if (bit_end && idle_bits != TO_W'(TIMEOUT_BITS))
          idle_bits <= idle_bits + 1'b1;
        if (idle_bits == TO_W'(TIMEOUT_BITS) && fifo_level != '0 && !to_fired) begin
          irq_timeout <= 1'b1;
          to_fired    <= 1'b1;
        end
      end
    end
  end
`else
  assign irq_timeout = 1'b0 & (TIMEOUT_BITS > 0);
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed self-checking bench for uart_rx_stream; divisor 2 gives 32 clocks per bit.
module tb_uart_rx_stream;
  localparam int BIT_CYC = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       ready_out = 1'b0;
  logic       valid_out;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic [5:0] fifo_level;
  logic       rx_done, overrun, irq_wm, irq_timeout;

  int vectors = 0;
  int miscompares = 0;

  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   valid_cyc = 0;
  int   to_cnt = 0;
  int   to_cyc = 0;
  logic valid_prev = 1'b0;

  uart_rx_stream #(
    .DATA_WIDTH   (8),
    .BAUDRATE     (3_906_250),
    .CLK_FREQ_MHZ (125),
    .OVERSAMPLE   (16),
    .FIFO_DEPTH   (16),
    .WATERMARK    (8),
    .TIMEOUT_BITS (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .cfg_parity  (cfg_parity),
    .cfg_stop2   (cfg_stop2),
    .clr_overrun (clr_overrun),
    .ready_out   (ready_out),
    .valid_out   (valid_out),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .fifo_level  (fifo_level),
    .rx_done     (rx_done),
    .overrun     (overrun),
    .irq_wm      (irq_wm),
    .irq_timeout (irq_timeout)
  );

  always #4 clk = ~clk;

  // Event monitor sampled on the inactive edge.
  always @(negedge clk) begin
    cyc        <= cyc + 1;
    valid_prev <= valid_out;
    if (rx_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (valid_out && !valid_prev) valid_cyc <= cyc;
    if (irq_timeout) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
  end

  task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par_bit,
                            input logic stop_a, input logic stop_b, input logic two_stop);
    logic [11:0] bits;
    int n;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = data[i]; n++; end
    if (par_en) begin bits[n] = par_bit; n++; end
    bits[n] = stop_a; n++;
    if (two_stop) begin bits[n] = stop_b; n++; end
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic pop_word;
    ready_out = 1'b1;
    @(negedge clk);
    ready_out = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", valid_out); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 00", rx_data); end
    vectors++; if (rx_err !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_err: got %b want 00", rx_err); end
    vectors++; if (fifo_level !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d want 0", fifo_level); end
    vectors++; if (rx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", rx_done); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
    vectors++; if (irq_wm !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_irq_wm: got %b want 0", irq_wm); end
    vectors++; if (irq_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_irq_to: got %b want 0", irq_timeout); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    int d0;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0; ready_out = 1'b0;
    d0 = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_valid: got %b want 1", valid_out); end
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("[TB] FAIL basic_data: got %h want a5", rx_data); end
    vectors++; if (rx_err !== 2'b00) begin miscompares++; $display("[TB] FAIL basic_err: got %b want 00", rx_err); end
    vectors++; if (valid_cyc - done_cyc !== 2) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d want 2", valid_cyc - done_cyc); end
    vectors++; if (fifo_level !== 6'd1) begin miscompares++; $display("[TB] FAIL basic_level: got %0d want 1", fifo_level); end
    vectors++; if (irq_wm !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_irq_wm: got %b want 0", irq_wm); end
    pop_word;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_pop_valid: got %b want 0", valid_out); end
    vectors++; if (fifo_level !== 6'd0) begin miscompares++; $display("[TB] FAIL basic_pop_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_parity;
    cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("[TB] FAIL even_bad_data: got %h want 3c", rx_data); end
    vectors++; if (rx_err !== 2'b01) begin miscompares++; $display("[TB] FAIL even_bad_err: got %b want 01", rx_err); end
    pop_word;
    cfg_parity = 2'b10;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("[TB] FAIL odd_ok_data: got %h want 3c", rx_data); end
    vectors++; if (rx_err !== 2'b00) begin miscompares++; $display("[TB] FAIL odd_ok_err: got %b want 00", rx_err); end
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("[TB] FAIL odd_ok_valid: got %b want 1", valid_out); end
    pop_word;
    cfg_parity = 2'b00;
  endtask

  task automatic test_stop2;
    int d0;
    cfg_parity = 2'b00; cfg_stop2 = 1'b1;
    d0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    cfg_stop2 = 1'b0;
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL stop2_done_count: got %0d want 1", done_cnt - d0); end
    vectors++; if (rx_data !== 8'h55) begin miscompares++; $display("[TB] FAIL stop2_data: got %h want 55", rx_data); end
    vectors++; if (rx_err !== 2'b10) begin miscompares++; $display("[TB] FAIL stop2_err: got %b want 10", rx_err); end
    pop_word;
  endtask

  task automatic test_glitch;
    int d0;
    d0 = done_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("[TB] FAIL glitch_done_count: got %0d want 0", done_cnt - d0); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_valid: got %b want 0", valid_out); end
    vectors++; if (fifo_level !== 6'd0) begin miscompares++; $display("[TB] FAIL glitch_level: got %0d want 0", fifo_level); end
  endtask

  // Back-to-back frames with the consumer stalled, then a full-rate drain.
  task automatic test_overrun;
    int d0;
    logic [7:0] exp;
    ready_out = 1'b0;
    d0 = done_cnt;
    for (int k = 0; k < 18; k++) begin
      send_frame(8'h20 + 8'(k), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (k == 6) begin
        vectors++; if (irq_wm !== 1'b0) begin miscompares++; $display("[TB] FAIL wm_below: got %b want 0", irq_wm); end
      end
      if (k == 7) begin
        vectors++; if (irq_wm !== 1'b1) begin miscompares++; $display("[TB] FAIL wm_at: got %b want 1", irq_wm); end
      end
      if (k == 16) begin
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL full_no_overrun: got %b want 0", overrun); end
      end
    end
    repeat (4) @(negedge clk);
    vectors++; if (done_cnt - d0 !== 18) begin miscompares++; $display("[TB] FAIL ovr_done_count: got %0d want 18", done_cnt - d0); end
    vectors++; if (fifo_level !== 6'd17) begin miscompares++; $display("[TB] FAIL ovr_level: got %0d want 17", fifo_level); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_flag: got %b want 1", overrun); end
    vectors++; if (irq_wm !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_irq_wm: got %b want 1", irq_wm); end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    @(negedge clk);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_clear: got %b want 0", overrun); end
    ready_out = 1'b1;
    for (int k = 0; k < 17; k++) begin
      exp = 8'h20 + 8'(k);
      vectors++; if (valid_out !== 1'b1 || rx_data !== exp) begin miscompares++; $display("[TB] FAIL drain_word_%0d: got v=%b d=%h want v=1 d=%h", k, valid_out, rx_data, exp); end
      @(negedge clk);
    end
    ready_out = 1'b0;
    @(negedge clk);
    vectors++; if (fifo_level !== 6'd0 || valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_empty: got lvl=%0d v=%b want 0 0", fifo_level, valid_out); end
  endtask

  task automatic test_reset_mid;
    int d0;
    ready_out = 1'b0;
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CYC + BIT_CYC / 2) @(negedge clk);
    pulse_reset;
    repeat (2 * BIT_CYC) @(negedge clk);
    d0 = done_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL rstmid_done_count: got %0d want 1", done_cnt - d0); end
    vectors++; if (rx_data !== 8'h81) begin miscompares++; $display("[TB] FAIL rstmid_data: got %h want 81", rx_data); end
    vectors++; if (rx_err !== 2'b00) begin miscompares++; $display("[TB] FAIL rstmid_err: got %b want 00", rx_err); end
    vectors++; if (fifo_level !== 6'd1) begin miscompares++; $display("[TB] FAIL rstmid_level: got %0d want 1", fifo_level); end
  endtask

  task automatic test_timeout;
    int t0;
    int start;
    pulse_reset;
    ready_out = 1'b0;
    send_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    start = cyc;
    t0 = to_cnt;
    repeat (40 * BIT_CYC) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
    vectors++; if (to_cnt - t0 !== 1) begin miscompares++; $display("[TB] FAIL timeout_count: got %0d want 1", to_cnt - t0); end
    vectors++; if (to_cyc - start < 30 * BIT_CYC || to_cyc - start > 34 * BIT_CYC) begin miscompares++; $display("[TB] FAIL timeout_delay: got %0d cycles want %0d..%0d", to_cyc - start, 30 * BIT_CYC, 34 * BIT_CYC); end
`else
    vectors++; if (to_cnt - t0 !== 0) begin miscompares++; $display("[TB] FAIL timeout_count: got %0d want 0", to_cnt - t0); end
`endif
    vectors++; if (fifo_level !== 6'd1) begin miscompares++; $display("[TB] FAIL timeout_level: got %0d want 1", fifo_level); end
  endtask

  initial begin
    $display("[TB] uart_rx_stream directed test start");
    test_reset;
    test_basic;
    test_parity;
    test_stop2;
    test_glitch;
    test_overrun;
    test_reset_mid;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
